// File: rtl/ultrasonic_scanner.sv
// ultrasonic_scanner: round-robin multi-channel ultrasonic ranging sequencer.
// Ports: clk, reset (async, active-high), enable (run/halt after current slot),
//   echo[N_CH] raw echo lines, trigger[N_CH] trigger pulses, dist_cm[16*N_CH]
//   latest distance per channel, timeout[N_CH] last-measurement timeout flags,
//   valid/valid_ch update strobe and its channel, busy (FSM not idle).
// Build option ULTRASONIC_RAW_DEBUG_EN adds raw_count[CNT_W*N_CH], the last
//   latched echo count per channel.
module ultrasonic_scanner #(
  parameter int N_CH = 4,
  parameter int TRIG_CYCLES = 120,
  parameter int SLOT_CYCLES = 750_000,
  parameter int TIMEOUT_CYCLES = 360_000,
  parameter int CM_DIV = 696,
  parameter int CNT_W = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic [N_CH-1:0] echo,
  output logic [N_CH-1:0] trigger,
  output logic [16*N_CH-1:0] dist_cm,
  output logic [N_CH-1:0] timeout,
  output logic valid,
  output logic [2:0] valid_ch,
`ifdef ULTRASONIC_RAW_DEBUG_EN
  output logic [CNT_W*N_CH-1:0] raw_count,
`endif
  output logic busy
);
  localparam int SLOT_W = $clog2(SLOT_CYCLES + 1);
  localparam logic [2:0] IDLE = 3'd0, TRIG = 3'd1, WAIT_RISE = 3'd2, MEASURE = 3'd3, DIVIDE = 3'd4, GAP = 3'd5;
  logic [2:0] state, ch, nxt_ch;
  logic [N_CH-1:0] echo_m, echo_s, echo_d, sel, nxt_sel;
  logic [SLOT_W-1:0] slot_cnt;
  logic [CNT_W-1:0] cnt, quo;
  logic rise, fall, to_hit, div_done, fin;
  logic [15:0] quo_sat;
  // echo_m/echo_s form the synchronizer; echo_d only delays echo_s for edge detection
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      echo_m <= '0;
      echo_s <= '0;
      echo_d <= '0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      echo_d <= echo_s;
    end
  // cnt doubles as rise-wait counter, echo-width counter and division remainder
  always_comb begin
    sel = N_CH'(1) << ch;
    nxt_ch = (ch == 3'(N_CH - 1)) ? 3'd0 : ch + 3'd1;
    nxt_sel = N_CH'(1) << nxt_ch;
    rise = |(sel & echo_s & ~echo_d);
    fall = |(sel & ~echo_s & echo_d);
    to_hit = (state == WAIT_RISE && !rise && cnt == CNT_W'(TIMEOUT_CYCLES - 1)) ||
             (state == MEASURE && cnt == CNT_W'(TIMEOUT_CYCLES));
    div_done = state == DIVIDE && cnt < CNT_W'(CM_DIV);
    fin = to_hit || div_done;
    quo_sat = (32'(quo) > 32'hFFFE) ? 16'hFFFE : 16'(quo);
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      ch <= '0;
      slot_cnt <= '0;
      cnt <= '0;
      quo <= '0;
      trigger <= '0;
      dist_cm <= '0;
      timeout <= '0;
      valid <= 1'b0;
      valid_ch <= '0;
    end else begin
      valid <= fin;
      if (state != IDLE) slot_cnt <= slot_cnt + 1'b1;
      if (fin) begin
        valid_ch <= ch;
        state <= GAP;
        for (int k = 0; k < N_CH; k++)
          if (sel[k]) begin
            dist_cm[16*k +: 16] <= to_hit ? 16'hFFFF : quo_sat;
            timeout[k] <= to_hit;
          end
      end
      case (state)
        IDLE: if (enable) begin
          state <= TRIG;
          slot_cnt <= '0;
          trigger <= sel;
        end
        TRIG: if (slot_cnt == SLOT_W'(TRIG_CYCLES - 1)) begin
          state <= WAIT_RISE;
          trigger <= '0;
          cnt <= '0;
        end
        WAIT_RISE: begin
          cnt <= rise ? '0 : cnt + 1'b1;
          if (rise) state <= MEASURE;
        end
        // cnt lags the high time by one, so cnt+1 at the fall is the full width
        MEASURE: begin
          cnt <= cnt + 1'b1;
          if (fall && !to_hit) begin
            state <= DIVIDE;
            quo <= '0;
          end
        end
        DIVIDE: if (!div_done) begin
          cnt <= cnt - CNT_W'(CM_DIV);
          quo <= quo + 1'b1;
        end
        GAP: if (slot_cnt >= SLOT_W'(SLOT_CYCLES - 1)) begin
          ch <= nxt_ch;
          slot_cnt <= '0;
          state <= enable ? TRIG : IDLE;
          trigger <= enable ? nxt_sel : '0;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef ULTRASONIC_RAW_DEBUG_EN
  logic [CNT_W-1:0] raw_lat;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      raw_lat <= '0;
      raw_count <= '0;
    end else begin
      if (state == MEASURE && fall) raw_lat <= cnt + 1'b1;
      if (fin)
        for (int k = 0; k < N_CH; k++)
          if (sel[k]) raw_count[CNT_W*k +: CNT_W] <= to_hit ? CNT_W'(TIMEOUT_CYCLES) : raw_lat;
    end
`endif
endmodule

// File: doc/ultrasonic_scanner.md
ULTRASONIC_SCANNER -- requirements
Module: ultrasonic_scanner

Interface
REQ-001 Parameter N_CH, default 4, number of sensor channels (1..8).
REQ-002 Parameter TRIG_CYCLES, default 120, trigger pulse width in clk cycles (10 us at 12 MHz).
REQ-003 Parameter SLOT_CYCLES, default 750_000, per-channel slot length in clk cycles (62.5 ms), measured from the trigger rising edge.
REQ-004 Parameter TIMEOUT_CYCLES, default 360_000, maximum wait for the echo rise and maximum echo width (30 ms).
REQ-005 Parameter CM_DIV, default 696, clk cycles of echo per centimetre.
REQ-006 Parameter CNT_W, default 24, echo counter width.
REQ-007 clk  input  1  system clock, 12 MHz.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 enable  input  1  high = scanning runs; low = scanner halts after the current slot.
REQ-010 echo  input  N_CH  raw echo lines, asynchronous to clk.
REQ-011 trigger  output  N_CH  per-channel trigger pulses.
REQ-012 dist_cm  output  16*N_CH  latest distance per channel; channel k occupies bits [16k+15:16k].
REQ-013 timeout  output  N_CH  sticky-per-measurement flag; bit k is 1 if the last measurement of channel k timed out.
REQ-014 valid  output  1  one-cycle strobe: dist_cm/timeout for valid_ch were updated this cycle.
REQ-015 valid_ch  output  3  channel index associated with valid.
REQ-016 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-017 Each echo bit SHALL pass through a 2-flop synchronizer; rise/fall SHALL be detected on the synchronized signal only.
REQ-018 FSM states SHALL be IDLE, TRIG, WAIT_RISE, MEASURE, DIVIDE, GAP.
REQ-019 IDLE: with enable=1 the FSM SHALL go to TRIG on the next cycle, with channel index ch at its current value (0 after reset).
REQ-020 TRIG: trigger[ch] SHALL be high for exactly TRIG_CYCLES cycles; all other trigger bits SHALL stay 0; then the FSM goes to WAIT_RISE.
REQ-021 The slot counter SHALL start at 0 on entry to TRIG and increment every cycle until the slot ends.
REQ-022 WAIT_RISE: on a synchronized rise of echo[ch], the FSM SHALL clear the echo counter and go to MEASURE.
REQ-023 WAIT_RISE: if no rise arrives within TIMEOUT_CYCLES of leaving TRIG, the FSM SHALL record a timeout for the channel.
REQ-024 MEASURE: the echo counter SHALL increment every cycle while in the state.
REQ-025 MEASURE: on a synchronized fall the FSM SHALL latch the count and go to DIVIDE.
REQ-026 MEASURE: if the count reaches TIMEOUT_CYCLES, the FSM SHALL record a timeout.
REQ-027 The count latched at the fall SHALL equal the number of clk cycles the synchronized echo was high.
REQ-028 DIVIDE SHALL compute floor(count/CM_DIV) by repeated subtraction, at one subtraction per cycle.
REQ-029 On completion of DIVIDE, dist_cm[ch] SHALL take the quotient, timeout[ch] SHALL clear, and valid SHALL pulse with valid_ch=ch; the FSM then goes to GAP.
REQ-030 On a timeout, dist_cm[ch] SHALL become 16'hFFFF, timeout[ch] SHALL set, and valid SHALL pulse with valid_ch=ch; the FSM then goes to GAP with no DIVIDE.
REQ-031 A quotient above 16'hFFFE SHALL saturate to 16'hFFFE.
REQ-032 GAP SHALL wait until the slot counter reaches SLOT_CYCLES-1.
REQ-033 At the end of GAP, ch SHALL advance modulo N_CH (N_CH-1 wraps to 0); the FSM goes to TRIG if enable=1, otherwise to IDLE.
REQ-034 Echo edges on channels other than ch, and any echo edge seen during TRIG, SHALL be ignored.
REQ-035 A rise and fall arriving in the same cycle cannot occur after synchronization; a fall seen in WAIT_RISE SHALL be ignored.
REQ-036 Deasserting enable mid-slot SHALL NOT abort the slot; the slot completes, including its valid strobe.

Reset
REQ-037 While reset=1, the following SHALL be held: trigger=0, dist_cm=0, timeout=0, valid=0, valid_ch=0, busy=0, ch=0, FSM=IDLE, all counters=0, synchronizers=0.
REQ-038 Reset asserted mid-operation SHALL abort immediately with no valid strobe.
REQ-039 After reset release, the first trigger SHALL start on channel 0.

Configuration
REQ-040 Macro ULTRASONIC_RAW_DEBUG_EN defined: the block SHALL add output raw_count [CNT_W*N_CH-1:0], which holds the last latched echo count per channel (TIMEOUT_CYCLES on a timeout), updated together with valid.
REQ-041 Macro ULTRASONIC_RAW_DEBUG_EN undefined: raw_count and its registers SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-042 Defaults, enable=1, echo[0] high 6960 cycles after its trigger -> dist_cm[15:0]=10, timeout[0]=0, valid with valid_ch=0.
REQ-043 Channel 1 echo never rises -> TIMEOUT_CYCLES cycles after TRIG ends: dist_cm[31:16]=16'hFFFF, timeout[1]=1, valid with valid_ch=1.
REQ-044 echo[2] pulsed while channel 0 is active -> dist_cm[47:32] unchanged; then channel 2 echo of 695 cycles -> dist_cm[47:32]=0.
REQ-045 Full 4-channel run -> triggers in order 0,1,2,3,0; rising edges exactly SLOT_CYCLES apart; only one trigger bit high at a time.
REQ-046 Reset asserted during MEASURE -> all outputs 0 within the cycle, no valid; after release the next trigger is on channel 0.
REQ-047 enable dropped during channel 1 WAIT_RISE -> the slot-1 valid still occurs, the FSM enters IDLE with ch=2, and no further triggers are issued.
